// File: rtl/kernel_key_irq_master.sv
// Avalon-MM initiator servicing the key PIO interrupt in hardware:
// unmask, read/clear edge_capture, sample key level, count, drive LEDs.
module kernel_key_irq_master #(
  parameter int                ADDR_W       = 4,
  parameter logic [ADDR_W-1:0] KEY_BASE     = 4'h0,
  parameter logic [ADDR_W-1:0] LED_BASE     = 4'h4,
  parameter int                READ_LATENCY = 1,
  parameter logic [15:0]       HOLDOFF      = 16'd50000,
  parameter int                CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              irq,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [CNT_W-1:0]  event_count,
  output logic              key_level,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_RD_EDGE = 3'd2,
    S_W_EDGE  = 3'd3,
    S_CLR     = 3'd4,
    S_RD_DATA = 3'd5,
    S_W_DATA  = 3'd6,
    S_LED_WR  = 3'd7
  } state_e;

  localparam logic [ADDR_W-1:0] A_DATA = KEY_BASE;
  localparam logic [ADDR_W-1:0] A_MASK = KEY_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_EDGE = KEY_BASE + ADDR_W'(3);
  localparam logic [1:0]        LAT_LAST = 2'(READ_LATENCY - 1);

  state_e            state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        lat_q, lat_d;
  logic              flag_q, flag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              key_q, key_d;
  logic [15:0]       hold_q, hold_d;
  logic              acc;
  logic              lat_done;
  logic              rdata_unused;

  // A request completes on an edge where it is presented and not stalled.
  assign acc      = (rd_q | wr_q) & ~avm_waitrequest;
  assign lat_done = (lat_q == LAT_LAST);
  assign rdata_unused = ^avm_readdata[31:1];

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: bus states advance on acceptance, wait states on latency.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:    if (acc) state_d = S_IDLE;
      S_IDLE:    if (irq && hold_q == 16'd0) state_d = S_RD_EDGE;
      S_RD_EDGE: if (acc) state_d = S_W_EDGE;
      S_W_EDGE:  if (lat_done) state_d = S_CLR;
      S_CLR:     if (acc) state_d = S_RD_DATA;
      S_RD_DATA: if (acc) state_d = S_W_DATA;
      S_W_DATA:  if (lat_done) state_d = flag_q ? S_LED_WR : S_IDLE;
      S_LED_WR:  if (acc) state_d = S_IDLE;
      default:   state_d = S_INIT;
    endcase
  end

  // Datapath next values: latency count, edge flag, counter, level, holdoff.
  always_comb begin
    lat_d  = 2'd0;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    key_d  = key_q;
    hold_d = hold_q;
    if (state_q == S_W_EDGE || state_q == S_W_DATA) begin
      lat_d = lat_done ? 2'd0 : lat_q + 2'd1;
    end
    if (state_q == S_W_EDGE && lat_done) begin
      flag_d = avm_readdata[0];
    end
    if (state_q == S_W_DATA && lat_done) begin
      key_d = avm_readdata[0];
      if (flag_q) cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == S_IDLE && hold_q != 16'd0) begin
      hold_d = hold_q - 16'd1;
    end
    if (state_q == S_LED_WR && acc) begin
      hold_d = HOLDOFF;
    end
  end

  // Bus request decode from the upcoming state, so requests are registered.
  always_comb begin
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_d)
      S_INIT: begin
        wr_d    = 1'b1;
        addr_d  = A_MASK;
        wdata_d = 32'h1;
      end
      S_RD_EDGE: begin
        rd_d   = 1'b1;
        addr_d = A_EDGE;
      end
      S_CLR: begin
        wr_d    = 1'b1;
        addr_d  = A_EDGE;
        wdata_d = 32'h0;
      end
      S_RD_DATA: begin
        rd_d   = 1'b1;
        addr_d = A_DATA;
      end
      S_LED_WR: begin
        wr_d    = 1'b1;
        addr_d  = LED_BASE;
        wdata_d = 32'(cnt_d);
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lat_q   <= 2'd0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      key_q   <= 1'b0;
      hold_q  <= 16'd0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lat_q   <= lat_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      hold_q  <= hold_d;
    end
  end

  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign event_count   = cnt_q;
  assign key_level     = key_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_kernel_key_irq_master.sv
// Bench for kernel_key_irq_master: key PIO slave model,
// vector table of key events, holdoff, wrap and reset corner cases.
module tb_kernel_key_irq_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        irq;
  logic [3:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest;
  logic [7:0]  event_count;
  logic        key_level;
  logic        busy;

  always #5 clk = ~clk;

  kernel_key_irq_master #(
    .ADDR_W(4),
    .KEY_BASE(4'h0),
    .LED_BASE(4'h4),
    .READ_LATENCY(1),
    .HOLDOFF(16'd10),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .irq(irq),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .event_count(event_count),
    .key_level(key_level),
    .busy(busy)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } xact_t;

  typedef struct {
    bit         spur;
    bit         key;
    int         stall;
    logic [7:0] exp_cnt;
    bit         exp_key;
  } vec_t;

  xact_t log_q[$];
  int    cyc = 0;
  int    stall = 0;
  int    wcnt = 0;
  logic  waitreq = 1'b0;
  logic  edge_cap = 1'b0;
  logic  irq_force = 1'b0;
  logic  mask = 1'b0;
  bit    key_val = 1'b0;
  int    press_n = 0, press_seen = 0;
  int    spur_n = 0, spur_seen = 0;

  int    checks = 0;
  int    failures = 0;
  logic  p_stall = 1'b0;
  logic [37:0] p_bus = '0;

  assign irq = (edge_cap & mask) | irq_force;
  assign avm_waitrequest = waitreq;

  // Key PIO slave with programmable stall per access
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((avm_read || avm_write) && !waitreq) begin
      log_q.push_back('{avm_write, avm_address, avm_writedata, cyc});
      waitreq <= (stall > 0);
      wcnt <= 0;
      if (avm_read) begin
        if (avm_address == 4'h3)
          avm_readdata <= {31'h2A5A5A5A, edge_cap};
        else
          avm_readdata <= {31'h3C3C3C3C, key_val};
      end
      if (avm_write && avm_address == 4'h3) begin
        edge_cap <= 1'b0;
        irq_force <= 1'b0;
      end
      if (avm_write && avm_address == 4'h2)
        mask <= avm_writedata[0];
    end else if (avm_read || avm_write) begin
      if (wcnt + 1 >= stall) waitreq <= 1'b0;
      else wcnt <= wcnt + 1;
    end else begin
      waitreq <= (stall > 0);
    end
    if (press_n != press_seen) begin
      edge_cap <= 1'b1;
      press_seen <= press_n;
    end
    if (spur_n != spur_seen) begin
      irq_force <= 1'b1;
      spur_seen <= spur_n;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_x(input string nm, input int idx, input bit wr,
                       input logic [3:0] addr, input bit cmpd,
                       input logic [31:0] data);
    checks++;
    if (idx >= log_q.size()) begin
      failures++;
      $display("FAIL %s missing xact got_n=%0d exp_idx=%0d",
               nm, log_q.size(), idx);
    end else if (log_q[idx].wr != wr || log_q[idx].addr !== addr ||
                 (cmpd && log_q[idx].data !== data)) begin
      failures++;
      $display("FAIL %s got=wr%0d a%h d%h exp=wr%0d a%h d%h", nm,
               log_q[idx].wr, log_q[idx].addr, log_q[idx].data,
               wr, addr, data);
    end
  endtask

  // One cycle, with request stability and exclusivity monitoring
  task automatic step();
    logic [37:0] bus;
    @(negedge clk);
    bus = {avm_read, avm_write, avm_address, avm_writedata};
    if (reset_n && avm_read && avm_write) begin
      checks++;
      failures++;
      $display("FAIL rd_wr_excl got=11 exp=not both");
    end
    if (p_stall) begin
      checks++;
      if (bus !== p_bus) begin
        failures++;
        $display("FAIL req_hold got=%h exp=%h", bus, p_bus);
      end
    end
    p_stall = reset_n && (avm_read || avm_write) && waitreq;
    p_bus = bus;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    n = 0;
    while (busy && n < 400) begin step(); n++; end
    chk({nm, "_done"}, 32'(busy), 32'h0);
  endtask

  task automatic wait_log(input string nm, input int sz);
    int n;
    n = 0;
    while (log_q.size() < sz && n < 100) begin step(); n++; end
    chk({nm, "_log_n"}, 32'(log_q.size() >= sz), 32'h1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_rd"}, 32'(avm_read), 32'h0);
    chk({nm, "_wr"}, 32'(avm_write), 32'h0);
    chk({nm, "_addr"}, 32'(avm_address), 32'h0);
    chk({nm, "_wdata"}, avm_writedata, 32'h0);
    chk({nm, "_cnt"}, 32'(event_count), 32'h0);
    chk({nm, "_key"}, 32'(key_level), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h1);
  endtask

  vec_t vecs[6];

  initial begin
    int base;
    int mcnt;
    int gap;

    vecs[0] = '{1'b0, 1'b0, 0, 8'd1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 3, 8'd2, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 0, 8'd2, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 2, 8'd2, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1, 8'd3, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 3, 8'd4, 1'b0};

    #2 reset_n = 1'b0;
    repeat (3) step();
    chk_reset("rst");
    reset_n = 1'b1;

    base = log_q.size();
    wait_done("init");
    chk("init_n", 32'(log_q.size() - base), 32'd1);
    chk_x("init_wr", base, 1'b1, 4'h2, 1'b1, 32'h1);
    chk("init_busy", 32'(busy), 32'h0);

    foreach (vecs[i]) begin
      stall = vecs[i].stall;
      key_val = vecs[i].key;
      repeat (3) step();
      base = log_q.size();
      if (vecs[i].spur) spur_n++;
      else press_n++;
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_cnt", i), 32'(event_count),
          32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_key", i), 32'(key_level),
          32'(vecs[i].exp_key));
      chk($sformatf("v%0d_n", i), 32'(log_q.size() - base),
          vecs[i].spur ? 32'd3 : 32'd4);
      chk_x($sformatf("v%0d_rdedge", i), base, 1'b0, 4'h3, 1'b0, '0);
      chk_x($sformatf("v%0d_clr", i), base + 1, 1'b1, 4'h3, 1'b1, '0);
      chk_x($sformatf("v%0d_rddata", i), base + 2, 1'b0, 4'h0, 1'b0, '0);
      if (!vecs[i].spur)
        chk_x($sformatf("v%0d_led", i), base + 3, 1'b1, 4'h4, 1'b1,
              32'(vecs[i].exp_cnt));
      repeat (12) step();
    end
    stall = 0;
    repeat (3) step();
    mcnt = 4;

    // Holdoff: second press during holdoff waits out 10 idle cycles
    base = log_q.size();
    press_n++;
    wait_log("ho_first", base + 4);
    repeat (2) step();
    press_n++;
    wait_log("ho_second", base + 5);
    chk_x("ho_rd", base + 4, 1'b0, 4'h3, 1'b0, '0);
    gap = (log_q.size() >= base + 5) ?
          log_q[base + 4].cyc - log_q[base + 3].cyc : -1;
    chk("ho_gap", 32'(gap), 32'd12);
    wait_done("ho");
    mcnt = mcnt + 2;
    chk("ho_cnt", 32'(event_count), 32'(mcnt));
    repeat (12) step();

    // Counter wrap
    while (mcnt < 255) begin
      press_n++;
      wait_done("fill");
      repeat (12) step();
      mcnt++;
    end
    chk("fill_cnt", 32'(event_count), 32'd255);
    base = log_q.size();
    press_n++;
    wait_done("wrap");
    chk("wrap_cnt", 32'(event_count), 32'd0);
    chk_x("wrap_led", base + 3, 1'b1, 4'h4, 1'b1, 32'h0);
    repeat (12) step();

    // Reset while the clear write is pending
    press_n++;
    begin
      int n;
      n = 0;
      while (!(avm_write && avm_address == 4'h3) && n < 50) begin
        step();
        n++;
      end
      chk("clr_seen", 32'(avm_write && avm_address == 4'h3), 32'h1);
    end
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    p_stall = 1'b0;
    step();
    base = log_q.size();
    reset_n = 1'b1;
    wait_log("reinit", base + 1);
    chk_x("reinit_wr", base, 1'b1, 4'h2, 1'b1, 32'h1);
    wait_done("after_rst");
    chk("after_rst_cnt", 32'(event_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
